ps2_rx_sequencer: RTL
=====================

# ps2_rx_sequencer

Receive-side controller for the PS/2 keyboard link. Synchronises PS2_CLK/PS2_DAT, sequences the 11-bit frame through a state machine with start/parity/stop validation and an inter-bit watchdog, folds F0/E0 prefix bytes into flags, and queues complete key events in a small FIFO. Downstream consumers (scan-code translation, key-lock logic) read events through a valid/ready handshake. This replaces free-running shift-register capture of the bus.

## Interface
- TIMEOUT_CYCLES, 50000: CLOCK_50 cycles allowed between falling PS2_CLK edges inside a frame (1 ms).
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2.
- CLOCK_50  input  1  system clock; the only clock.
- RESET  input  1  asynchronous, active-high reset.
- PS2_CLK  input  1  raw PS/2 clock from the keyboard; asynchronous to CLOCK_50.
- PS2_DAT  input  1  raw PS/2 data from the keyboard; asynchronous.
- EVT_CODE  output  8  scan code of the head event.
- EVT_BREAK  output  1  head event was preceded by F0 (key release).
- EVT_EXT  output  1  head event was preceded by E0 (extended key).
- EVT_VALID  output  1  FIFO non-empty.
- EVT_READY  input  1  consumer accepts head event when EVT_VALID & EVT_READY.
- FRAME_ERR  output  1  one-cycle pulse on any rejected frame.
- OVERFLOW  output  1  sticky; set when an event is dropped because the FIFO is full.

## Operation
- Two-flop synchronisers on PS2_CLK and PS2_DAT; falling edge = prev synced clk 1, current 0. All sampling occurs on that edge-detect cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge, if DAT=0 → DATA, bit count=0; if DAT=1 → stay IDLE, pulse FRAME_ERR.
  - DATA: shift DAT in LSB-first; after the 8th bit → PARITY.
  - PARITY: store bit → STOP.
  - STOP: if DAT=1 and parity is good → byte accepted; otherwise FRAME_ERR, byte discarded. Always → IDLE.
- Watchdog: counter clears on every edge and in IDLE; in any non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE, pulses FRAME_ERR, and clears the prefix flags.
- Prefix decoder on an accepted byte: F0 sets brk_flag; E0 sets ext_flag; any other byte pushes {ext_flag, brk_flag, byte} and clears both flags. A dropped push (FIFO full) also clears the flags.
- FIFO: push when not full. Pop on EVT_VALID & EVT_READY. Simultaneous push and pop when full: both take effect and the count is unchanged. Simultaneous push and pop when empty: the push takes effect and no pop occurs.
- OVERFLOW clears only on RESET.
- Reset values: FSM IDLE, all counters 0, flags 0, FIFO empty, EVT_VALID=0, EVT_CODE=00, EVT_BREAK=0, EVT_EXT=0, FRAME_ERR=0, OVERFLOW=0. Synchroniser flops reset to 1 (bus idle high).
- RESET mid-frame: the partial frame is lost. After release, the receiver waits for the next start bit.

## Timing
- A raw PS2_CLK fall is seen by edge detect 3 cycles later (2 sync + 1 edge).
- Stop bit sampled in cycle N → FIFO write at N+1 → EVT_VALID high at N+2 when the FIFO was empty.
- Pop takes effect at the clock edge. The next head event appears on EVT_* the following cycle, with no bubble.
- EVT_* outputs are stable while EVT_VALID=1 and EVT_READY=0.
- FRAME_ERR is high for exactly 1 cycle per error.

## Configuration
- PS2_PARITY_CHECK_EN defined: odd parity is enforced; a bad parity bit gives FRAME_ERR and the byte is discarded.
- PS2_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored. Only the start and stop bits are checked.

## Test plan
- Frame for 1C (good odd parity=0, stop=1) with EVT_READY=1 → one event: CODE=1C, BREAK=0, EXT=0; EVT_VALID high for 1 cycle.
- Sequence E0, F0, 74 with EVT_READY=0 → single event: CODE=74, EXT=1, BREAK=1. The following byte 1C → second event with flags 0.
- 1C frame with parity=1 → FRAME_ERR pulse and no event. Repeat the same frame with PS2_PARITY_CHECK_EN undefined → event CODE=1C.
- Stop PS2_CLK after 4 data bits for >TIMEOUT_CYCLES → FRAME_ERR at the timeout. A subsequent full 32 frame → event CODE=32.
- With EVT_READY=0, send 5 codes 15,1D,24,2D,2C → first 4 are queued and OVERFLOW=1. Raise EVT_READY → pops 15,1D,24,2D in order, then EVT_VALID=0.
- Assert RESET after 6 bits of a frame, then send a full 5A frame → only CODE=5A is delivered; OVERFLOW=0, FRAME_ERR not asserted.

Source files
------------

// File: rtl/ps2_rx_sequencer_if.sv
// ps2_rx_sequencer_if -- key-event bus from the PS/2 receiver to its consumer.
//   EVT_CODE/EVT_BREAK/EVT_EXT : head event (scan code, F0 seen, E0 seen)
//   EVT_VALID / EVT_READY      : valid/ready handshake, transfer on both high
//   FRAME_ERR                  : one-cycle pulse per rejected frame
//   OVERFLOW                   : sticky, an event was dropped on a full FIFO
// master = receiver side, slave = consumer side.
interface ps2_rx_sequencer_if;
  logic [7:0] EVT_CODE;
  logic       EVT_BREAK;
  logic       EVT_EXT;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic       FRAME_ERR;
  logic       OVERFLOW;

  modport master (
    output EVT_CODE, EVT_BREAK, EVT_EXT, EVT_VALID, FRAME_ERR, OVERFLOW,
    input  EVT_READY
  );

  modport slave (
    input  EVT_CODE, EVT_BREAK, EVT_EXT, EVT_VALID, FRAME_ERR, OVERFLOW,
    output EVT_READY
  );
endinterface

// File: rtl/ps2_rx_sequencer.sv
// ps2_rx_sequencer -- PS/2 keyboard receive controller.
// Synchronises PS2_CLK/PS2_DAT, walks each 11-bit frame through an FSM
// (start/data/parity/stop) guarded by an inter-bit watchdog, folds F0/E0
// prefixes into flags and queues complete key events in a small FIFO.
// Ports:
//   CLOCK_50 : system clock (only clock)
//   RESET    : asynchronous active-high reset
//   PS2_CLK  : raw keyboard clock (asynchronous)
//   PS2_DAT  : raw keyboard data (asynchronous)
//   evt      : event bus (ps2_rx_sequencer_if.master)
// Parameters: TIMEOUT_CYCLES (watchdog limit between falling edges),
//             FIFO_DEPTH (event entries, power of two >= 2).
// Build option: define PS2_PARITY_CHECK_EN to enforce odd parity; otherwise
// the parity bit is sampled and ignored.
module ps2_rx_sequencer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET,
  input  logic                   PS2_CLK,
  input  logic                   PS2_DAT,
  ps2_rx_sequencer_if.master     evt
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  // ---------------- synchronisers and falling-edge detect ----------------
  // Sync flops reset high (idle bus) so release from reset never fakes an edge.
  // The edge pulse and the data sample are registered together so the data
  // bit is always aligned with its edge.
  logic [1:0] clk_sync, dat_sync;
  logic       clk_prev, fall_q, dat_q;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
      fall_q   <= 1'b0;
      dat_q    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      clk_prev <= clk_sync[1];
      fall_q   <= clk_prev & ~clk_sync[1];
      dat_q    <= dat_sync[1];
    end
  end

  // ---------------- frame FSM ----------------
  state_t          state, state_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shreg, shreg_n;
  logic            par_bit, par_bit_n;
  logic [WD_W-1:0] wd_cnt, wd_cnt_n;
  logic            err_n, acc_n, timeout;
  logic            parity_ok;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shreg, par_bit};   // odd parity over data + parity
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    err_n     = 1'b0;
    acc_n     = 1'b0;
    timeout   = 1'b0;
    wd_cnt_n  = (state == IDLE || fall_q) ? '0 : wd_cnt + 1'b1;

    // Watchdog wins over a coincident edge: the frame is already stale.
    if (state != IDLE && wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
      state_n  = IDLE;
      err_n    = 1'b1;
      timeout  = 1'b1;
      wd_cnt_n = '0;
    end else if (fall_q) begin
      unique case (state)
        IDLE: begin
          if (!dat_q) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end
        DATA: begin
          shreg_n   = {dat_q, shreg[7:1]};   // LSB first
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_bit_n = dat_q;
          state_n   = STOP;
        end
        STOP: begin
          if (dat_q && parity_ok) acc_n = 1'b1;
          else                    err_n = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par_bit <= par_bit_n;
      wd_cnt  <= wd_cnt_n;
    end
  end

  // ---------------- prefix decode + event FIFO ----------------
  logic          acc_vld, frame_err, overflow, brk_flag, ext_flag;
  logic [7:0]    acc_byte;
  evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          is_f0, is_e0, push_req, full, pop, push, drop;

  assign is_f0    = (acc_byte == 8'hF0);
  assign is_e0    = (acc_byte == 8'hE0);
  assign push_req = acc_vld & ~is_f0 & ~is_e0;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = (count != '0) & evt.EVT_READY;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      acc_vld   <= 1'b0;
      acc_byte  <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      brk_flag  <= 1'b0;
      ext_flag  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      acc_vld   <= acc_n;
      if (acc_n) acc_byte <= shreg;
      frame_err <= err_n;
      if (drop) overflow <= 1'b1;

      // Timeout and accept never coincide: acc_vld is only set in IDLE.
      if (timeout) begin
        brk_flag <= 1'b0;
        ext_flag <= 1'b0;
      end else if (acc_vld) begin
        if (is_f0)      brk_flag <= 1'b1;
        else if (is_e0) ext_flag <= 1'b1;
        else begin
          brk_flag <= 1'b0;
          ext_flag <= 1'b0;
        end
      end

      if (push) begin
        mem[wr_ptr] <= '{ext: ext_flag, brk: brk_flag, code: acc_byte};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign evt.EVT_VALID = (count != '0);
  assign evt.EVT_CODE  = mem[rd_ptr].code;
  assign evt.EVT_BREAK = mem[rd_ptr].brk;
  assign evt.EVT_EXT   = mem[rd_ptr].ext;
  assign evt.FRAME_ERR = frame_err;
  assign evt.OVERFLOW  = overflow;
endmodule
